axis_rr_arbiter: RTL and testbench
==================================

// Module: axis_rr_arbiter
// PURPOSE
//  N-to-1 round-robin arbiter for AXI-stream style valid/ready channels.
//  Shares one downstream stream (typically the AXI_stream_top FIFO input)
//  among N upstream requesters; holds a grant for a bounded burst, then
//  rotates. Reports the granted source index alongside the data.
// PARAMETERS
//  width     4  data bits per beat
//  n_in      4  number of upstream requesters (>=2)
//  burst_max 4  max beats transferred per grant before forced release (>=1)
// PORTS
//  clk         in   1             clock, all state on rising edge
//  rst         in   1             reset, asynchronous, active-high
//  up_valid    in   n_in          per-requester valid
//  up_ready    out  n_in          per-requester ready
//  up_data     in   n_in*width    requester i at [i*width +: width]
//  down_valid  out  1             downstream valid
//  down_ready  in   1             downstream ready
//  down_data   out  width         downstream data
//  down_src    out  clog2(n_in)   index of granted requester
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, grant idx=0, ptr=n_in-1, beat cnt=0;
//    down_valid=0, up_ready=all 0, down_src=0, down_data=0.
//  - FSM states IDLE, BUSY.
//  - IDLE: down_valid=0, up_ready=0. Search from ptr+1 upward, wrapping at
//    n_in-1 -> 0; first i with up_valid[i]=1 latched as grant, cnt=0,
//    -> BUSY next cycle. No request -> stay IDLE, ptr unchanged.
//  - BUSY (grant g): down_valid=up_valid[g], down_data=up_data[g],
//    down_src=g, up_ready[g]=down_ready, up_ready[j!=g]=0. Combinational
//    mux; zero latency through the block while granted.
//  - Transfer = up_valid[g] & down_ready; cnt increments per transfer.
//  - Release -> IDLE, ptr=g, when: transfer with cnt==burst_max-1, or
//    up_valid[g]=0 in a BUSY cycle. Release costs one IDLE bubble cycle.
//  - Backpressure (down_ready=0): no transfer, cnt/grant held, data stable.
//  - Single active requester: burst_max beats, 1 bubble, regranted.
//  - down_data/down_src are 0 whenever down_valid=0.
//  - cnt width clog2(burst_max+1); never exceeds burst_max-1 in BUSY.
//  - Reset mid-burst: returns to reset state immediately; in-flight beat
//    not transferred (no handshake seen by either side).
// CONFIGURATION
//  AXIS_ARB_LAST_EN defined:
//   - adds up_last in n_in and down_last out 1 (=up_last[g] in BUSY, else 0)
//   - release only on transfer with up_last[g]=1, or up_valid[g]=0 in BUSY;
//     burst_max ignored (packets never interleaved)
//  AXIS_ARB_LAST_EN undefined: no last ports; burst_max rule as above.
// TESTING (n_in=4, width=4, burst_max=4; scoreboard keyed by down_src)
//  1. up_valid=4'b1111, down_ready=1 constant -> down_src 0,1,2,3,0 in
//     runs of 4 beats each, exactly one down_valid=0 cycle between runs.
//  2. Only up_valid[2]=1, down_ready=1 -> 4 beats src 2, 1 bubble, repeat;
//     up_ready[0,1,3] never 1.
//  3. ch1 granted, down_ready=0 for 5 cycles -> down_valid=1, down_data
//     stable, up_ready[1]=0, cnt frozen; resumes counting when ready=1.
//  4. ch0 valid drops after 2 beats, ch0+ch1 requesting again next ->
//     release, next grant is ch1 (ptr=0), not ch0.
//  5. rst pulsed at beat 2 of ch3 burst -> all outputs 0 same cycle; first
//     grant after reset with all valid = ch0; no lost/duplicated data.
//  6. AXIS_ARB_LAST_EN: ch3 sends 6-beat packet, last on beat 6, ch0 also
//     valid -> 6 contiguous src 3 beats, down_last on 6th, then ch0.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Round-robin N-to-1 arbiter for valid/ready streams, burst-bounded grants.
// Latency: zero (combinational mux) while granted; one idle bubble per re-grant.
// Backpressure: down_ready is routed straight to the granted up_ready; others see 0.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   up_valid/up_ready/up_data per-requester stream, requester i at [i*width +: width]
//   down_valid/down_ready/down_data/down_src  shared output stream + granted index
//   up_last/down_last         only when AXIS_ARB_LAST_EN is defined: grants are
//                             held for a whole packet instead of burst_max beats
module axis_rr_arbiter #(
  parameter int width     = 4,
  parameter int n_in      = 4,
  parameter int burst_max = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [n_in-1:0]            up_valid,
  output logic [n_in-1:0]            up_ready,
  input  logic [n_in*width-1:0]      up_data,
`ifdef AXIS_ARB_LAST_EN
  input  logic [n_in-1:0]            up_last,
  output logic                       down_last,
`endif
  output logic                       down_valid,
  input  logic                       down_ready,
  output logic [width-1:0]           down_data,
  output logic [$clog2(n_in)-1:0]    down_src
);

  localparam int IW = $clog2(n_in);
  localparam int CW = $clog2(burst_max + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(burst_max - 1);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   grant, grant_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic            xfer;
  logic            end_of_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= IW'(n_in - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    up_ready     = '0;
    down_valid   = 1'b0;
    down_data    = '0;
    down_src     = '0;
`ifdef AXIS_ARB_LAST_EN
    down_last    = 1'b0;
`endif
    found        = 1'b0;
    pick         = '0;
    cand         = '0;
    xfer         = 1'b0;
    end_of_grant = 1'b0;

    case (state)
      IDLE: begin
        // Scan starts just after the last owner so it becomes lowest priority.
        for (int k = 1; k <= n_in; k++) begin
          cand = IW'((int'(ptr) + k) % n_in);
          if (!found && up_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
          end
        end
        if (found) begin
          state_nxt = BUSY;
          grant_nxt = pick;
          cnt_nxt   = '0;
        end
      end

      BUSY: begin
        down_valid      = up_valid[grant];
        up_ready[grant] = down_ready;
        // Data and index are forced to zero whenever the beat is not valid.
        if (up_valid[grant]) begin
          down_data = up_data[grant*width +: width];
          down_src  = grant;
        end
        xfer = up_valid[grant] & down_ready;
`ifdef AXIS_ARB_LAST_EN
        down_last    = up_last[grant];
        end_of_grant = xfer & up_last[grant];
`else
        end_of_grant = xfer & (cnt == CNT_LAST);
`endif
        if (!up_valid[grant] || end_of_grant) begin
          state_nxt = IDLE;
          ptr_nxt   = grant;
          cnt_nxt   = '0;
        end else if (xfer) begin
`ifdef AXIS_ARB_LAST_EN
          // Beat count is informational only here; saturate so long packets never wrap.
          cnt_nxt = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;
`else
          cnt_nxt = cnt + 1'b1;
`endif
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter (n_in=4, width=4, burst_max=4).
// Requester i presents data {i, seq_i[1:0]}; seq_i advances on each upstream handshake.
// Expected beats (src, data, idle gap before beat, last) are queued by the stimulus.
module tb_axis_rr_arbiter;
  localparam int W = 4;
  localparam int N = 4;
  localparam int B = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   up_valid;
  logic [N-1:0]   up_ready;
  logic [N*W-1:0] up_data;
  logic           down_valid;
  logic           down_ready;
  logic [W-1:0]   down_data;
  logic [1:0]     down_src;
`ifdef AXIS_ARB_LAST_EN
  logic [N-1:0]   up_last;
  logic           down_last;
`endif

  always #5 clk = ~clk;

  axis_rr_arbiter #(.width(W), .n_in(N), .burst_max(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
`ifdef AXIS_ARB_LAST_EN
    .up_last    (up_last),
    .down_last  (down_last),
`endif
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_src   (down_src)
  );

  typedef struct {
    int         src;
    logic [W-1:0] data;
    int         gap;   // idle (down_valid=0) cycles before this beat; -1 = don't care
    bit         last;
  } exp_t;

  exp_t         sbq[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           seq[N]     = '{default: 0};
  int           exp_seq[N] = '{default: 0};
  int           hs_total = 0;
  int           gap_cnt  = 0;
  logic [N-1:0] hs_vec   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic push(input int src, input int gap, input bit last);
    exp_t e;
    e.src  = src;
    e.data = {2'(src), 2'(exp_seq[src])};
    e.gap  = gap;
    e.last = last;
    exp_seq[src]++;
    sbq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target);
    int budget;
    budget = 300;
    while (hs_total < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check("hs_reached", 32'(hs_total >= target), 32'd1);
  endtask

  task automatic drain(input string name);
    repeat (3) cyc();
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  // Upstream source model: data per requester follows its own beat counter.
  always_comb begin
    for (int i = 0; i < N; i++) up_data[i*W +: W] = {2'(i), 2'(seq[i])};
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) if (hs_vec[i]) seq[i]++;
  end

  // Monitor: per-cycle invariants plus scoreboard pop on each downstream handshake.
  always @(negedge clk) begin
    exp_t e;
    hs_vec = '0;
    if (!rst) begin
      hs_vec = up_valid & up_ready;
      if (!down_valid) begin
        gap_cnt++;
        check("idle_data_zero", 32'(down_data), 32'd0);
        check("idle_src_zero", 32'(down_src), 32'd0);
      end else begin
        check("ready_route", 32'(up_ready), down_ready ? (32'd1 << down_src) : 32'd0);
      end
      if (down_valid && down_ready) begin
        hs_total++;
        check("up_hs_matches_src", 32'(hs_vec), 32'd1 << down_src);
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got src=%0d data=%0h, required no beat", down_src, down_data);
        end else begin
          e = sbq.pop_front();
          check("beat_src", 32'(down_src), 32'(e.src));
          check("beat_data", 32'(down_data), 32'(e.data));
          if (e.gap >= 0) check("beat_gap", 32'(gap_cnt), 32'(e.gap));
`ifdef AXIS_ARB_LAST_EN
          check("beat_last", 32'(down_last), 32'(e.last));
`endif
        end
        gap_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    rst        = 1'b1;
    up_valid   = '0;
    down_ready = 1'b0;
`ifdef AXIS_ARB_LAST_EN
    up_last    = '0;
`endif
    #2;
    check("rst_down_valid", 32'(down_valid), 32'd0);
    check("rst_up_ready", 32'(up_ready), 32'd0);
    check("rst_down_src", 32'(down_src), 32'd0);
    check("rst_down_data", 32'(down_data), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;

`ifndef AXIS_ARB_LAST_EN
    // 1: all requesting -> 0,1,2,3,0 in runs of 4, one bubble between runs.
    b = hs_total;
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 4; k++)
        push(r % 4, (r == 0 && k == 0) ? -1 : (k == 0 ? 1 : 0), 1'b0);
    down_ready = 1'b1;
    up_valid   = 4'b1111;
    wait_hs(b + 20);
    cyc();
    up_valid = '0;
    drain("t1_drained");

    // 2: single requester ch2 -> 4 beats, bubble, regrant.
    b = hs_total;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++)
        push(2, (r == 0 && k == 0) ? -1 : (k == 0 ? 1 : 0), 1'b0);
    up_valid = 4'b0100;
    wait_hs(b + 8);
    cyc();
    up_valid = '0;
    drain("t2_drained");

    // 3: ch1 stalled 5 cycles after first beat; burst count resumes after.
    b = hs_total;
    push(1, -1, 1'b0);
    push(1, 0, 1'b0);
    push(1, 0, 1'b0);
    push(1, 0, 1'b0);
    push(1, 1, 1'b0);
    up_valid = 4'b0010;
    wait_hs(b + 1);
    cyc();
    down_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("stall_valid", 32'(down_valid), 32'd1);
      check("stall_data", 32'(down_data), 32'h5);
      check("stall_src", 32'(down_src), 32'd1);
      check("stall_up_ready", 32'(up_ready), 32'd0);
    end
    cyc();
    down_ready = 1'b1;
    wait_hs(b + 5);
    cyc();
    up_valid = '0;
    drain("t3_drained");

    // 4: ch0 drops after 2 beats; ch0+ch1 then request -> ch1 first.
    b = hs_total;
    push(0, -1, 1'b0);
    push(0, 0, 1'b0);
    push(1, 2, 1'b0);
    for (int k = 0; k < 3; k++) push(1, 0, 1'b0);
    push(0, 1, 1'b0);
    for (int k = 0; k < 3; k++) push(0, 0, 1'b0);
    up_valid = 4'b0001;
    wait_hs(b + 2);
    cyc();
    up_valid = '0;
    cyc();
    up_valid = 4'b0011;
    wait_hs(b + 10);
    cyc();
    up_valid = '0;
    drain("t4_drained");

    // 5: reset during second beat of a ch3 burst; that beat is resent later.
    b = hs_total;
    push(3, -1, 1'b0);
    up_valid = 4'b1000;
    wait_hs(b + 1);
    @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(down_valid), 32'd1);
    check("pre_rst_data", 32'(down_data), 32'hD);
    rst = 1'b1;
    #1;
    check("mid_rst_down_valid", 32'(down_valid), 32'd0);
    check("mid_rst_up_ready", 32'(up_ready), 32'd0);
    check("mid_rst_down_src", 32'(down_src), 32'd0);
    check("mid_rst_down_data", 32'(down_data), 32'd0);
    cyc();
    rst = 1'b0;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++)
        push(s, (s == 0 && k == 0) ? -1 : (k == 0 ? 1 : 0), 1'b0);
    up_valid = 4'b1111;
    wait_hs(b + 17);
    cyc();
    up_valid = '0;
    drain("t5_drained");
`else
    // 6: ch3 6-beat packet (last on 6th) held despite ch0 waiting, then ch0.
    b = hs_total;
    push(3, -1, 1'b0);
    for (int k = 0; k < 4; k++) push(3, 0, 1'b0);
    push(3, 0, 1'b1);
    push(0, 1, 1'b1);
    down_ready = 1'b1;
    up_last    = 4'b0001;
    up_valid   = 4'b1000;
    cyc();
    up_valid = 4'b1001;
    wait_hs(b + 5);
    cyc();
    up_last[3] = 1'b1;
    wait_hs(b + 6);
    cyc();
    up_valid[3] = 1'b0;
    up_last[3]  = 1'b0;
    wait_hs(b + 7);
    cyc();
    up_valid = '0;
    drain("t6_drained");
`endif

    repeat (5) cyc();
    check("final_queue_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
